kernel_bc_start_token_consumer: RTL and testbench

Read side of the kernel_bc dataflow start-token channels. The block joins the start tokens from NUM_SRC upstream start FIFOs and drives the ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue) of one downstream dataflow process. It bounds the number of outstanding invocations and returns completions to the outer controller through a valid/ready pair.

---
 rtl/kernel_bc_pkg.sv | 22 ++
 rtl/kernel_bc_start_token_slot.sv | 36 +++
 rtl/kernel_bc_start_token_consumer.sv | 83 ++++++++
 tb/tb_kernel_bc_start_token_consumer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_bc_pkg.sv
// Shared constants and helpers for the kernel_bc dataflow start-token logic.
package kernel_bc_pkg;

  localparam int KBC_MAX_SRC      = 8;
  localparam int KBC_MAX_INFLIGHT = 15;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_state_e;

  // Never returns less than 1 so a counter sized with it always has a bit.
  function automatic int kbc_clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/kernel_bc_start_token_slot.sv
// One start-token holding slot: pops a token when empty, or refills on the
// same cycle the joined start fires so back-to-back starts need no bubble.
module kernel_bc_start_token_slot
  import kernel_bc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic src_empty_n,
  input  logic fire,
  output logic src_read,
  output logic tok_vld
);

  slot_state_e state_q;
  slot_state_e state_d;

  assign src_read = ~reset & src_empty_n & ((state_q == SLOT_EMPTY) | fire);

  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = SLOT_EMPTY;
    end else if (src_read) begin
      state_d = SLOT_HELD;
    end else if (fire) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign tok_vld = (state_q == SLOT_HELD);

endmodule

// File: rtl/kernel_bc_start_token_consumer.sv
// Joins NUM_SRC start tokens into ap_ctrl_chain starts, bounds outstanding
// invocations to MAX_INFLIGHT and hands completions back over done_valid/done_ready.
module kernel_bc_start_token_consumer
  import kernel_bc_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_empty_n,
  output logic [NUM_SRC-1:0] src_read,
  output logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  output logic               ap_continue,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               idle,
  output logic [CNT_W-1:0]   start_count
);

  localparam int INF_W = kbc_clog2(MAX_INFLIGHT + 1);
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

  logic [NUM_SRC-1:0] tok_vld;
  logic               fire;
  logic               retire;
  logic               busy;
  logic [INF_W-1:0]   inflight_q;
  logic [INF_W-1:0]   inflight_d;
  logic [CNT_W-1:0]   start_count_q;
  logic [CNT_W-1:0]   start_count_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    kernel_bc_start_token_slot u_slot (
      .clk         (clk),
      .reset       (reset),
      .src_empty_n (src_empty_n[i]),
      .fire        (fire),
      .src_read    (src_read[i]),
      .tok_vld     (tok_vld[i])
    );
  end

  // ap_start looks only at registers so ap_ready never loops back into it.
  assign busy     = (inflight_q != '0);
  assign ap_start = (&tok_vld) & (inflight_q < INF_MAX);
  assign fire     = ap_start & ap_ready;

  // A done with nothing in flight is a downstream protocol error and is dropped.
  assign done_valid  = ap_done & busy;
  assign ap_continue = done_valid & done_ready;
  assign retire      = ap_continue;

  always_comb begin
    inflight_d    = inflight_q;
    start_count_d = start_count_q;
    if (reset) begin
      inflight_d    = '0;
      start_count_d = '0;
    end else begin
      if (fire && !retire) begin
        inflight_d = inflight_q + INF_W'(1);
      end else if (retire && !fire) begin
        inflight_d = inflight_q - INF_W'(1);
      end
      if (fire) begin
        start_count_d = start_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    inflight_q    <= inflight_d;
    start_count_q <= start_count_d;
  end

  assign idle        = ~(|tok_vld) & ~busy;
  assign start_count = start_count_q;

endmodule

// File: tb/tb_kernel_bc_start_token_consumer.sv
// Directed scenarios for the start-token consumer; every accepted start is
// matched against a queue of expected start numbers built as tokens are loaded.
module tb_kernel_bc_start_token_consumer;

  localparam int NS = 2;
  localparam int CW = 32;

  logic          clk;
  logic          reset;
  logic [NS-1:0] src_empty_n;
  logic [NS-1:0] src_read;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic          ap_continue;
  logic          done_valid;
  logic          done_ready;
  logic          idle;
  logic [CW-1:0] start_count;

  int n_tests;
  int n_fail;
  int avail [NS];
  int loaded[NS];
  int pushed;
  int inf_m;
  int exp_q[$];

  kernel_bc_start_token_consumer #(
    .NUM_SRC      (NS),
    .MAX_INFLIGHT (2),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_empty_n (src_empty_n),
    .src_read    (src_read),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .idle        (idle),
    .start_count (start_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_empty_n();
    for (int i = 0; i < NS; i++) src_empty_n[i] = (avail[i] != 0);
  endtask

  // Upstream FIFO model: each complete token set is one future start.
  task automatic load(input int s, input int n);
    int sets;
    avail[s]  += n;
    loaded[s] += n;
    sets = (loaded[0] < loaded[1]) ? loaded[0] : loaded[1];
    while (pushed < sets) begin
      pushed++;
      exp_q.push_back(pushed);
    end
    drive_empty_n();
  endtask

  // Called at a negedge: samples outputs, crosses the edge, updates the models.
  task automatic tick();
    logic          rst_s;
    logic          fire_s;
    logic          ret_s;
    logic [NS-1:0] rd_s;
    int            e;
    rst_s  = reset;
    fire_s = ap_start & ap_ready;
    ret_s  = ap_continue;
    rd_s   = src_read;
    @(posedge clk);
    #1;
    if (rst_s === 1'b1) begin
      for (int i = 0; i < NS; i++) begin
        avail[i]  = 0;
        loaded[i] = 0;
      end
      pushed = 0;
      inf_m  = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < NS; i++) if (rd_s[i] === 1'b1) avail[i]--;
      if (fire_s === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_start: start_count=%0d, no start was expected", start_count);
        end else begin
          e = exp_q.pop_front();
          if (start_count !== CW'(e)) begin
            n_fail++;
            $display("FAIL sb_start_count: got %0d want %0d", start_count, e);
          end
        end
        inf_m++;
      end
      if (ret_s === 1'b1) inf_m--;
    end
    drive_empty_n();
  endtask

  task automatic cyc();
    @(negedge clk);
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && inf_m != 0; k++) begin
      ap_done    = 1'b1;
      done_ready = 1'b1;
      cyc();
    end
    ap_done    = 1'b0;
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    src_empty_n = 2'b11;
    ap_done     = 1'b1;
    done_ready  = 1'b1;
    ap_ready    = 1'b1;
    @(negedge clk);
    n_tests += 6;
    if (src_read !== 2'b00) begin n_fail++; $display("FAIL rst_src_read: got %b want 00", src_read); end
    if (ap_start !== 1'b0) begin n_fail++; $display("FAIL rst_ap_start: got %b want 0", ap_start); end
    if (ap_continue !== 1'b0) begin n_fail++; $display("FAIL rst_ap_continue: got %b want 0", ap_continue); end
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid: got %b want 0", done_valid); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", idle); end
    if (start_count !== '0) begin n_fail++; $display("FAIL rst_start_count: got %0d want 0", start_count); end
    tick();
    ap_done    = 1'b0;
    done_ready = 1'b0;
  endtask

  task automatic test_reset_release();
    load(0, 1);
    load(1, 1);
    reset    = 1'b0;
    ap_ready = 1'b1;
    @(negedge clk);
    n_tests += 2;
    if (src_read !== 2'b11) begin n_fail++; $display("FAIL rr_src_read: got %b want 11", src_read); end
    if (ap_start !== 1'b0) begin n_fail++; $display("FAIL rr_ap_start_early: got %b want 0", ap_start); end
    tick();
    @(negedge clk);
    n_tests++;
    if (ap_start !== 1'b1) begin n_fail++; $display("FAIL rr_ap_start: got %b want 1", ap_start); end
    tick();
    @(negedge clk);
    n_tests++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL rr_busy: idle got %b want 0", idle); end
    tick();
    ap_done    = 1'b1;
    done_ready = 1'b1;
    @(negedge clk);
    n_tests += 2;
    if (done_valid !== 1'b1) begin n_fail++; $display("FAIL rr_done_valid: got %b want 1", done_valid); end
    if (ap_continue !== 1'b1) begin n_fail++; $display("FAIL rr_ap_continue: got %b want 1", ap_continue); end
    tick();
    ap_done    = 1'b0;
    done_ready = 1'b0;
    @(negedge clk);
    n_tests += 2;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL rr_idle: got %b want 1", idle); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_pending: got %0d starts pending want 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_skew();
    ap_ready = 1'b1;
    load(0, 1);
    @(negedge clk);
    n_tests++;
    if (src_read !== 2'b01) begin n_fail++; $display("FAIL sk_first_pop: got %b want 01", src_read); end
    tick();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_tests += 3;
      if (src_read !== 2'b00) begin n_fail++; $display("FAIL sk_no_repop c%0d: got %b want 00", c, src_read); end
      if (ap_start !== 1'b0) begin n_fail++; $display("FAIL sk_no_start c%0d: got %b want 0", c, ap_start); end
      if (dut.tok_vld[0] !== 1'b1) begin n_fail++; $display("FAIL sk_held c%0d: got %b want 1", c, dut.tok_vld[0]); end
      tick();
    end
    load(1, 1);
    @(negedge clk);
    n_tests += 3;
    if (src_read !== 2'b10) begin n_fail++; $display("FAIL sk_second_pop: got %b want 10", src_read); end
    if (ap_start !== 1'b0) begin n_fail++; $display("FAIL sk_start_c5: got %b want 0", ap_start); end
    if (dut.tok_vld[0] !== 1'b1) begin n_fail++; $display("FAIL sk_held_c5: got %b want 1", dut.tok_vld[0]); end
    tick();
    @(negedge clk);
    n_tests++;
    if (ap_start !== 1'b1) begin n_fail++; $display("FAIL sk_start_c6: got %b want 1", ap_start); end
    tick();
    @(negedge clk);
    n_tests++;
    if (dut.tok_vld !== 2'b00) begin n_fail++; $display("FAIL sk_consumed: got %b want 00", dut.tok_vld); end
    tick();
    drain();
    @(negedge clk);
    n_tests += 2;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL sk_idle: got %b want 1", idle); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sk_pending: got %0d want 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [6:0] fires;
    fires      = '0;
    ap_ready   = 1'b1;
    done_ready = 1'b1;
    load(0, 4);
    load(1, 4);
    for (int c = 0; c < 7; c++) begin
      ap_done = (inf_m != 0);
      @(negedge clk);
      fires[c] = ap_start & ap_ready;
      n_tests++;
      if (dut.inflight_q > 1) begin n_fail++; $display("FAIL b2b_inflight c%0d: got %0d want <=1", c, dut.inflight_q); end
      tick();
    end
    ap_done    = 1'b0;
    done_ready = 1'b0;
    @(negedge clk);
    n_tests += 3;
    if (fires !== 7'b0011110) begin n_fail++; $display("FAIL b2b_fire_cycles: got %b want 0011110", fires); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", idle); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_inflight_bound();
    ap_ready   = 1'b1;
    ap_done    = 1'b0;
    done_ready = 1'b0;
    load(0, 3);
    load(1, 3);
    cyc();
    cyc();
    cyc();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests += 3;
      if (ap_start !== 1'b0) begin n_fail++; $display("FAIL ib_saturated c%0d: got %b want 0", c, ap_start); end
      if (dut.tok_vld !== 2'b11) begin n_fail++; $display("FAIL ib_held c%0d: got %b want 11", c, dut.tok_vld); end
      if (src_read !== 2'b00) begin n_fail++; $display("FAIL ib_no_pop c%0d: got %b want 00", c, src_read); end
      tick();
    end
    ap_done    = 1'b1;
    done_ready = 1'b1;
    @(negedge clk);
    n_tests += 2;
    if (ap_continue !== 1'b1) begin n_fail++; $display("FAIL ib_continue: got %b want 1", ap_continue); end
    if (ap_start !== 1'b0) begin n_fail++; $display("FAIL ib_start_same_cycle: got %b want 0", ap_start); end
    tick();
    ap_done    = 1'b0;
    done_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ap_start !== 1'b1) begin n_fail++; $display("FAIL ib_reenabled: got %b want 1", ap_start); end
    tick();
    @(negedge clk);
    n_tests++;
    if (ap_start !== 1'b0) begin n_fail++; $display("FAIL ib_resaturated: got %b want 0", ap_start); end
    tick();
    drain();
    @(negedge clk);
    n_tests += 2;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL ib_idle: got %b want 1", idle); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ib_pending: got %0d want 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_backpressure();
    ap_ready = 1'b1;
    load(0, 1);
    load(1, 1);
    cyc();
    cyc();
    ap_done    = 1'b1;
    done_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests += 3;
      if (done_valid !== 1'b1) begin n_fail++; $display("FAIL bp_done_valid c%0d: got %b want 1", c, done_valid); end
      if (ap_continue !== 1'b0) begin n_fail++; $display("FAIL bp_continue c%0d: got %b want 0", c, ap_continue); end
      if (dut.inflight_q !== 2'd1) begin n_fail++; $display("FAIL bp_inflight c%0d: got %0d want 1", c, dut.inflight_q); end
      tick();
    end
    done_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ap_continue !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", ap_continue); end
    tick();
    @(negedge clk);
    n_tests += 3;
    if (ap_continue !== 1'b0) begin n_fail++; $display("FAIL bp_single_retire: got %b want 0", ap_continue); end
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_second_done: got %b want 0", done_valid); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b want 1", idle); end
    tick();
    ap_done    = 1'b0;
    done_ready = 1'b0;
  endtask

  task automatic test_protocol_reset();
    ap_ready   = 1'b1;
    ap_done    = 1'b1;
    done_ready = 1'b1;
    @(negedge clk);
    n_tests += 2;
    if (ap_continue !== 1'b0) begin n_fail++; $display("FAIL pe_continue: got %b want 0", ap_continue); end
    if (done_valid !== 1'b0) begin n_fail++; $display("FAIL pe_done_valid: got %b want 0", done_valid); end
    tick();
    ap_done    = 1'b0;
    done_ready = 1'b0;
    load(0, 1);
    load(1, 1);
    cyc();
    cyc();
    load(0, 1);
    cyc();
    @(negedge clk);
    n_tests += 3;
    if (dut.tok_vld !== 2'b01) begin n_fail++; $display("FAIL pr_held: got %b want 01", dut.tok_vld); end
    if (idle !== 1'b0) begin n_fail++; $display("FAIL pr_busy: got %b want 0", idle); end
    if (start_count !== 32'd11) begin n_fail++; $display("FAIL pr_count_before: got %0d want 11", start_count); end
    tick();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    n_tests += 3;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL pr_idle: got %b want 1", idle); end
    if (start_count !== '0) begin n_fail++; $display("FAIL pr_start_count: got %0d want 0", start_count); end
    if (ap_start !== 1'b0) begin n_fail++; $display("FAIL pr_ap_start: got %b want 0", ap_start); end
    tick();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    pushed      = 0;
    inf_m       = 0;
    for (int i = 0; i < NS; i++) begin
      avail[i]  = 0;
      loaded[i] = 0;
    end
    reset       = 1'b1;
    src_empty_n = '0;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    done_ready  = 1'b0;
    test_reset();
    test_reset_release();
    test_skew();
    test_back_to_back();
    test_inflight_bound();
    test_backpressure();
    test_protocol_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
